// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-boundary double buffering.
// Optional leading-zero blanking is compiled in when DISP_LZB_EN is defined.
module display_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP_CYC  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [8*DIGITS-1:0]   data,
  output logic [7:0]            code,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int unsigned CMAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned IW   = $clog2(DIGITS);

  localparam logic [CW-1:0]     SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [7:0]        BLANK     = 8'h14;
  localparam logic [DIGITS-1:0] SEL_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic {SHOW, GAP} state_t;

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    run;
  logic                    adv;
  logic                    wrap;
  logic                    commit;
  logic                    pend, pend_n;
  logic [DIGITS-1:0][7:0]  pending, pending_n;
  logic [DIGITS-1:0][7:0]  shadow, shadow_n;
  logic [7:0]              code_d;
  logic [DIGITS-1:0]       sel_d;
  logic                    fd_d;

  // Registers hold the slot being shown after each edge; outputs are
  // registered from the next-slot values so they align with the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SHOW;
      idx        <= '0;
      cnt        <= '0;
      run        <= 1'b0;
      pend       <= 1'b0;
      pending    <= {DIGITS{BLANK}};
      shadow     <= {DIGITS{BLANK}};
      code       <= BLANK;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      run        <= en;
      pend       <= pend_n;
      pending    <= pending_n;
      shadow     <= shadow_n;
      code       <= code_d;
      digit_sel  <= sel_d;
      frame_done <= fd_d;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    adv     = 1'b0;
    wrap    = 1'b0;
    if (!en || !run) begin
      // Disabled, or first enabled edge: (re)start at digit 0 without a wrap.
      state_n = SHOW;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        SHOW: begin
          if (cnt != SHOW_LAST) begin
            cnt_n = cnt + 1'b1;
          end else if (GAP_CYC > 0) begin
            state_n = GAP;
            cnt_n   = '0;
          end else begin
            adv = 1'b1;
          end
        end
        GAP: begin
          if (cnt != GAP_LAST) cnt_n = cnt + 1'b1;
          else                 adv   = 1'b1;
        end
        default: adv = 1'b1;
      endcase
      if (adv) begin
        state_n = SHOW;
        cnt_n   = '0;
        if (idx != IDX_LAST) begin
          idx_n = idx + 1'b1;
        end else begin
          idx_n = '0;
          wrap  = 1'b1;
        end
      end
    end
  end

  // A load coinciding with a commit keeps pend set so the new data waits a frame.
  always_comb begin
    commit    = pend & (wrap | ~run | ~en);
    shadow_n  = shadow;
    pending_n = pending;
    if (commit) shadow_n = pending;
    if (load)   pending_n = data;
    pend_n    = load | (pend & ~commit);
  end

`ifdef DISP_LZB_EN
  logic [DIGITS-1:0] lzb;
  logic              lz_run;

  always_comb begin
    lzb    = '0;
    lz_run = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run & (shadow_n[i] == 8'h00);
      lzb[i] = lz_run;
    end
  end
`endif

  always_comb begin
    sel_d  = '0;
    code_d = BLANK;
    fd_d   = 1'b0;
    if (en) begin
      fd_d = wrap;
      if (state_n == SHOW) begin
        sel_d  = SEL_ONE << idx_n;
        code_d = shadow_n[idx_n];
`ifdef DISP_LZB_EN
        if (lzb[idx_n]) code_d = BLANK;
`endif
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: DIGITS=4, SCAN_DIV=4, one instance
// with GAP_CYC=1 (scoreboarded) and one with GAP_CYC=0 (frame period only).
module tb_display_scan_ctrl;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] code;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] data;
  logic [7:0]  code0, code1;
  logic [3:0]  sel0, sel1;
  logic        fd0, fd1;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          per0    = -1;
  int          per1    = -1;
  logic [3:0]  prev1   = '0;

  display_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .GAP_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .code(code0), .digit_sel(sel0), .frame_done(fd0)
  );

  display_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .GAP_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .code(code1), .digit_sel(sel1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] exp_code(input logic [31:0] d, input int i);
    logic [31:0] v;
    logic [7:0]  c;
`ifdef DISP_LZB_EN
    bit z;
`endif
    v = d >> (8 * i);
    c = v[7:0];
`ifdef DISP_LZB_EN
    z = (i > 0);
    for (int j = i; j < 4; j++)
      if (((d >> (8 * j)) & 32'hff) != 32'h0) z = 1'b0;
    if (z) c = 8'h14;
`endif
    return c;
  endfunction

  task automatic push_part(input logic [31:0] d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.sel  = 4'b0001 << i;
      e.code = exp_code(d, i);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_fd();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!fd1 && i < 40);
    n_tests++;
    if (!fd1) begin
      n_fail++;
      $display("FAIL fd_timeout: frame_done=0 after %0d cycles, required 1", i);
    end
  endtask

  // Push next frame's expectation, optionally load mid-frame, then wait for the wrap.
  task automatic frame_step(input logic [31:0] nxt, input int n_nxt,
                            input bit do_load, input logic [31:0] ld);
    push_part(nxt, n_nxt);
    repeat (5) @(negedge clk);
    if (do_load) begin
      load = 1'b1;
      data = ld;
      @(negedge clk);
      load = 1'b0;
    end
    wait_fd();
  endtask

  // Monitor: samples after each active edge and checks against the queue.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      prev1 = '0;
      per0  = -1;
      per1  = -1;
    end else if (!en) begin
      chk("dark_sel", sel1, 4'b0000);
      chk("dark_code", code1, 8'h14);
      chk("dark_fd", fd1, 1'b0);
      per0  = -1;
      per1  = -1;
      prev1 = sel1;
    end else begin
      if (sel1 == 4'b0000) chk("gap_code", code1, 8'h14);
      if (sel1 != 4'b0000 && sel1 != prev1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: digit_sel=0x%0h code=0x%0h shown, required no display", sel1, code1);
        end else begin
          e = exp_q.pop_front();
          chk("digit_sel", sel1, e.sel);
          chk("digit_code", code1, e.code);
        end
      end
      prev1 = sel1;
      if (fd1) begin
        chk("fd_sel1", sel1, 4'b0001);
        if (per1 >= 0) chk("period_gap1", per1, 20);
        per1 = 1;
      end else if (per1 >= 0) begin
        per1++;
      end
      if (fd0) begin
        chk("fd_sel0", sel0, 4'b0001);
        if (per0 >= 0) chk("period_gap0", per0, 16);
        per0 = 1;
      end else if (per0 >= 0) begin
        per0++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("reset_code", code1, 8'h14);
    chk("reset_sel", sel1, 4'b0000);
    chk("reset_fd", fd1, 1'b0);
    chk("reset_code0", code0, 8'h14);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Blank frames, then a mid-frame load, then a second mid-frame load.
    push_part(32'h14141414, 4);
    en = 1'b1;
    frame_step(32'h14141414, 4, 1'b0, 32'h0);
    frame_step(32'h03020100, 4, 1'b1, 32'h03020100);
    frame_step(32'h09090909, 4, 1'b1, 32'h09090909);

    // Load A mid-frame, then load B on the wrap edge: A shows next, B after.
    push_part(32'h04040404, 4);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 5) begin load = 1'b1; data = 32'h04040404; end
      if (k == 6) load = 1'b0;
      if (k == 19) begin load = 1'b1; data = 32'h07070707; end
    end
    @(negedge clk);
    chk("wrap_fd", fd1, 1'b1);
    load = 1'b0;
    frame_step(32'h07070707, 2, 1'b0, 32'h0);

    // Disable for 10 cycles mid-scan with a load in between.
    repeat (6) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    load = 1'b1;
    data = 32'h080a1503;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    push_part(32'h080a1503, 4);
    push_part(32'h080a1503, 4);
    en = 1'b1;
    @(negedge clk);
    chk("reen_fd", fd1, 1'b0);
    chk("reen_sel", sel1, 4'b0001);
    wait_fd();

    // Leading-zero patterns.
    frame_step(32'h05000000, 4, 1'b1, 32'h05000000);
    frame_step(32'h00000000, 4, 1'b1, 32'h00000000);
    frame_step(32'h00150000, 4, 1'b1, 32'h00150000);

    // Reset mid-scan: immediate blank, pending data discarded.
    repeat (7) @(negedge clk);
    chk("sb_level", exp_q.size(), 2);
    load = 1'b1;
    data = 32'h01010101;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_sel", sel1, 4'b0000);
    chk("async_rst_code", code1, 8'h14);
    chk("async_rst_fd", fd1, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_part(32'h14141414, 4);
    push_part(32'h14141414, 4);
    rst = 1'b1;
    wait_fd();
    repeat (17) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
